mem_access_stage: RTL and testbench

MEM-stage consumer of the EX/MEM pipeline register outputs in the RV32 pipelined core.

- Issues word loads and stores to the data memory over a req/ready handshake and stalls the front of the pipeline while an access is outstanding.
- Resolves branch-taken for the PC mux.
- Registers the resolved writeback result, which is either the load data or the ALU result, into the MEM/WB fields.

---
 rtl/mem_access_stage.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_stage.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: issues word loads/stores on a req/ready bus, resolves branches, registers MEM/WB fields.
// Latency: non-memory op 1 cycle; memory op 2 cycles plus the dmem_ready latency (bounded by TIMEOUT).
// Backpressure: mem_stall holds the upstream pipeline while an access is being issued or is outstanding.
//
// Ports:
//   clk, reset                 clock (rising edge), asynchronous active-high reset
//   pc_in, alu_in              branch target and ALU result / byte address from EX/MEM
//   read_data2_in, wr_in       store data and destination register from EX/MEM
//   branch_in .. zero_in       EX/MEM control fields
//   dmem_*                     data memory request bus (req held until ready)
//   mem_stall                  hold PC, IF/ID, ID/EX and EX/MEM
//   pcsrc_out                  branch taken
//   branch_target_out          branch target (pass-through of pc_in)
//   wb_data, wb_rd             registered writeback value and destination
//   wb_regwrite                registered writeback enable
//   misalign_fault, bus_fault  one-cycle fault pulses
module mem_access_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] read_data2_in,
  input  logic [4:0]  wr_in,
  input  logic        branch_in,
  input  logic        memread_in,
  input  logic        memreg_in,
  input  logic        memwrite_in,
  input  logic        regwrite_in,
  input  logic        zero_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        mem_stall,
  output logic        pcsrc_out,
  output logic [31:0] branch_target_out,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_regwrite,
  output logic        misalign_fault,
  output logic        bus_fault
);

  // Watchdog fires in the ACCESS cycle where the counter shows TIMEOUT-1,
  // i.e. at the edge ending the TIMEOUT-th ACCESS cycle. TIMEOUT=0 disables it.
  localparam bit          WD_EN   = (TIMEOUT > 0);
  localparam logic [31:0] WD_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [31:0] wd_cnt;
  logic [4:0]  lat_wr;
  logic        lat_regwrite;
  logic        lat_use_rdata;

  logic        mem_op;
  logic        aligned;
  logic        is_store;
  logic        wd_expire;

  assign mem_op    = memread_in | memwrite_in;
  assign aligned   = (alu_in[1:0] == 2'b00);
  // Read and write asserted together is a store.
  assign is_store  = memwrite_in;
  assign wd_expire = WD_EN && (wd_cnt == WD_LAST);

  // Branches only resolve while the stage is idle; during an access the
  // EX/MEM register is frozen and the decision belongs to the stalled op.
  assign pcsrc_out         = branch_in & zero_in & (state_q == IDLE);
  assign branch_target_out = pc_in;

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Next state and stall
  // ---------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    mem_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_op && aligned) begin
          mem_stall = 1'b1;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        if (dmem_ready || wd_expire) begin
          state_d = DONE;
        end
      end
      // Stall drops here so upstream advances past the finished op.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Request bus, latched op fields, watchdog and MEM/WB registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_req       <= 1'b0;
      dmem_we        <= 1'b0;
      dmem_addr      <= 32'd0;
      dmem_wdata     <= 32'd0;
      wb_data        <= 32'd0;
      wb_rd          <= 5'd0;
      wb_regwrite    <= 1'b0;
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
      wd_cnt         <= 32'd0;
      lat_wr         <= 5'd0;
      lat_regwrite   <= 1'b0;
      lat_use_rdata  <= 1'b0;
    end else begin
      misalign_fault <= 1'b0;
      bus_fault      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mem_op && aligned) begin
            dmem_req      <= 1'b1;
            dmem_we       <= is_store;
            dmem_addr     <= {alu_in[31:2], 2'b00};
            dmem_wdata    <= read_data2_in;
            lat_wr        <= wr_in;
            lat_regwrite  <= regwrite_in;
            // Only a genuine load routed through memreg returns bus data;
            // anything else writes back the address (ALU result).
            lat_use_rdata <= memread_in & memreg_in & ~is_store;
            wd_cnt        <= 32'd0;
            wb_regwrite   <= 1'b0;
          end else if (mem_op) begin
            misalign_fault <= 1'b1;
            wb_regwrite    <= 1'b0;
          end else begin
            wb_data     <= alu_in;
            wb_rd       <= wr_in;
            wb_regwrite <= regwrite_in;
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            dmem_req    <= 1'b0;
            wb_data     <= lat_use_rdata ? dmem_rdata : dmem_addr;
            wb_rd       <= lat_wr;
            wb_regwrite <= lat_regwrite;
          end else if (wd_expire) begin
            dmem_req    <= 1'b0;
            bus_fault   <= 1'b1;
            wb_regwrite <= 1'b0;
          end else begin
            wd_cnt      <= wd_cnt + 32'd1;
            wb_regwrite <= 1'b0;
          end
        end
        DONE: begin
          wb_regwrite <= 1'b0;
        end
        default: begin
          wb_regwrite <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] alu_in;
  logic [31:0] read_data2_in;
  logic [4:0]  wr_in;
  logic        branch_in;
  logic        memread_in;
  logic        memreg_in;
  logic        memwrite_in;
  logic        regwrite_in;
  logic        zero_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        mem_stall;
  logic        pcsrc_out;
  logic [31:0] branch_target_out;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_regwrite;
  logic        misalign_fault;
  logic        bus_fault;

  int tests;
  int fails;

  mem_access_stage #(.TIMEOUT(4)) dut (
    .clk               (clk),
    .reset             (reset),
    .pc_in             (pc_in),
    .alu_in            (alu_in),
    .read_data2_in     (read_data2_in),
    .wr_in             (wr_in),
    .branch_in         (branch_in),
    .memread_in        (memread_in),
    .memreg_in         (memreg_in),
    .memwrite_in       (memwrite_in),
    .regwrite_in       (regwrite_in),
    .zero_in           (zero_in),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_ready        (dmem_ready),
    .dmem_rdata        (dmem_rdata),
    .mem_stall         (mem_stall),
    .pcsrc_out         (pcsrc_out),
    .branch_target_out (branch_target_out),
    .wb_data           (wb_data),
    .wb_rd             (wb_rd),
    .wb_regwrite       (wb_regwrite),
    .misalign_fault    (misalign_fault),
    .bus_fault         (bus_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_bubble();
    pc_in         = 32'd0;
    alu_in        = 32'd0;
    read_data2_in = 32'd0;
    wr_in         = 5'd0;
    branch_in     = 1'b0;
    memread_in    = 1'b0;
    memreg_in     = 1'b0;
    memwrite_in   = 1'b0;
    regwrite_in   = 1'b0;
    zero_in       = 1'b0;
  endtask

  task automatic set_load(input logic [31:0] addr, input logic [4:0] rd);
    set_bubble();
    alu_in      = addr;
    wr_in       = rd;
    memread_in  = 1'b1;
    memreg_in   = 1'b1;
    regwrite_in = 1'b1;
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    set_bubble();
    tick();
    tick();
    tests++;
    if ({dmem_req, dmem_we, wb_regwrite, misalign_fault, bus_fault, mem_stall} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: got %b expected 000000",
               {dmem_req, dmem_we, wb_regwrite, misalign_fault, bus_fault, mem_stall});
    end
    tests++;
    if ({dmem_addr, dmem_wdata, wb_data, wb_rd} !== 101'd0) begin
      fails++;
      $display("FAIL reset_data: addr=%h wdata=%h wb_data=%h wb_rd=%0d expected all 0",
               dmem_addr, dmem_wdata, wb_data, wb_rd);
    end
    reset = 1'b0;
    // Start a load and assert reset while it is outstanding.
    set_load(32'h300, 5'd4);
    tick();
    tests++;
    if (dmem_req !== 1'b1) begin
      fails++;
      $display("FAIL reset_pre_req: dmem_req got %b expected 1", dmem_req);
    end
    reset = 1'b1;
    set_bubble();
    #1;
    tests++;
    if ({dmem_req, wb_regwrite, mem_stall, bus_fault} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_mid_access: req/regwrite/stall/bus_fault got %b expected 0000",
               {dmem_req, wb_regwrite, mem_stall, bus_fault});
    end
    tick();
    reset = 1'b0;
    // A fresh ALU op must go straight through from IDLE.
    alu_in      = 32'h55;
    wr_in       = 5'd2;
    regwrite_in = 1'b1;
    #1;
    tests++;
    if (mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL reset_after_stall: got %b expected 0", mem_stall);
    end
    tick();
    tests++;
    if (wb_data !== 32'h55 || wb_rd !== 5'd2 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL reset_after_wb: wb_data=%h wb_rd=%0d wb_regwrite=%b expected 00000055 2 1",
               wb_data, wb_rd, wb_regwrite);
    end
    set_bubble();
    tick();
  endtask

  task automatic test_alu();
    int stalls;
    stalls = 0;
    set_bubble();
    alu_in      = 32'h1234;
    wr_in       = 5'd5;
    regwrite_in = 1'b1;
    #1;
    if (mem_stall) stalls++;
    tick();
    if (mem_stall) stalls++;
    tests++;
    if (wb_data !== 32'h1234 || wb_rd !== 5'd5 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL alu_wb: wb_data=%h wb_rd=%0d wb_regwrite=%b expected 00001234 5 1",
               wb_data, wb_rd, wb_regwrite);
    end
    tests++;
    if (stalls !== 0) begin
      fails++;
      $display("FAIL alu_stall: stall cycles got %0d expected 0", stalls);
    end
    set_bubble();
    tick();
    tests++;
    if (wb_regwrite !== 1'b0) begin
      fails++;
      $display("FAIL bubble_wb: wb_regwrite got %b expected 0", wb_regwrite);
    end
  endtask

  task automatic test_load();
    int stalls;
    int bad_bus;
    stalls  = 0;
    bad_bus = 0;
    set_load(32'h100, 5'd7);
    #1;
    if (mem_stall) stalls++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (mem_stall) stalls++;
      if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_we !== 1'b0) bad_bus++;
      if (i == 2) begin
        dmem_ready = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
      end
    end
    tick();
    dmem_ready = 1'b0;
    dmem_rdata = 32'd0;
    #1;
    if (mem_stall) stalls++;
    tests++;
    if (bad_bus !== 0) begin
      fails++;
      $display("FAIL load_bus: bad req/addr/we cycles got %0d expected 0", bad_bus);
    end
    tests++;
    if (wb_data !== 32'hDEADBEEF || wb_rd !== 5'd7 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL load_wb: wb_data=%h wb_rd=%0d wb_regwrite=%b expected deadbeef 7 1",
               wb_data, wb_rd, wb_regwrite);
    end
    tests++;
    if (dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL load_req_drop: dmem_req got %b expected 0", dmem_req);
    end
    tests++;
    if (stalls !== 4) begin
      fails++;
      $display("FAIL load_stall: stall cycles got %0d expected 4", stalls);
    end
    tick();
    set_bubble();
    #1;
    tests++;
    if (wb_regwrite !== 1'b0 || wb_data !== 32'hDEADBEEF) begin
      fails++;
      $display("FAIL load_wb_pulse: wb_regwrite=%b wb_data=%h expected 0 deadbeef",
               wb_regwrite, wb_data);
    end
    tick();
  endtask

  task automatic test_store();
    int stalls;
    stalls = 0;
    set_bubble();
    alu_in        = 32'h204;
    read_data2_in = 32'hA5A5A5A5;
    memwrite_in   = 1'b1;
    wr_in         = 5'd9;
    #1;
    if (mem_stall) stalls++;
    tick();
    if (mem_stall) stalls++;
    tests++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h204 || dmem_wdata !== 32'hA5A5A5A5) begin
      fails++;
      $display("FAIL store_bus: req=%b we=%b addr=%h wdata=%h expected 1 1 00000204 a5a5a5a5",
               dmem_req, dmem_we, dmem_addr, dmem_wdata);
    end
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    #1;
    if (mem_stall) stalls++;
    tests++;
    if (wb_regwrite !== 1'b0 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL store_done: wb_regwrite=%b dmem_req=%b expected 0 0", wb_regwrite, dmem_req);
    end
    tests++;
    if (stalls !== 2) begin
      fails++;
      $display("FAIL store_stall: stall cycles got %0d expected 2", stalls);
    end
    tick();
    set_bubble();
    tick();
  endtask

  task automatic test_misalign();
    set_bubble();
    alu_in      = 32'h77;
    wr_in       = 5'd1;
    regwrite_in = 1'b1;
    tick();
    set_load(32'h102, 5'd3);
    #1;
    tests++;
    if (mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL misalign_stall: got %b expected 0", mem_stall);
    end
    tick();
    tests++;
    if (misalign_fault !== 1'b1 || dmem_req !== 1'b0 || wb_regwrite !== 1'b0) begin
      fails++;
      $display("FAIL misalign_pulse: fault=%b req=%b wb_regwrite=%b expected 1 0 0",
               misalign_fault, dmem_req, wb_regwrite);
    end
    set_bubble();
    tick();
    tests++;
    if (misalign_fault !== 1'b0 || dmem_req !== 1'b0) begin
      fails++;
      $display("FAIL misalign_clear: fault=%b req=%b expected 0 0", misalign_fault, dmem_req);
    end
  endtask

  task automatic test_timeout();
    int req_cycles;
    req_cycles = 0;
    set_load(32'h80, 5'd6);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (dmem_req) req_cycles++;
      if (bus_fault) req_cycles = req_cycles + 100;
    end
    tick();
    tests++;
    if (req_cycles !== 4) begin
      fails++;
      $display("FAIL timeout_req_cycles: got %0d expected 4", req_cycles);
    end
    tests++;
    if (bus_fault !== 1'b1 || dmem_req !== 1'b0 || wb_regwrite !== 1'b0 || mem_stall !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort: bus_fault=%b req=%b wb_regwrite=%b stall=%b expected 1 0 0 0",
               bus_fault, dmem_req, wb_regwrite, mem_stall);
    end
    tick();
    set_bubble();
    branch_in = 1'b1;
    zero_in   = 1'b1;
    #1;
    tests++;
    if (bus_fault !== 1'b0 || pcsrc_out !== 1'b1) begin
      fails++;
      $display("FAIL timeout_idle: bus_fault=%b pcsrc=%b expected 0 1", bus_fault, pcsrc_out);
    end
    set_bubble();
    tick();
  endtask

  task automatic test_branch();
    set_bubble();
    branch_in = 1'b1;
    zero_in   = 1'b1;
    pc_in     = 32'h40;
    #1;
    tests++;
    if (pcsrc_out !== 1'b1 || branch_target_out !== 32'h40) begin
      fails++;
      $display("FAIL branch_taken: pcsrc=%b target=%h expected 1 00000040", pcsrc_out, branch_target_out);
    end
    zero_in = 1'b0;
    pc_in   = 32'h88;
    #1;
    tests++;
    if (pcsrc_out !== 1'b0 || branch_target_out !== 32'h88) begin
      fails++;
      $display("FAIL branch_not_taken: pcsrc=%b target=%h expected 0 00000088", pcsrc_out, branch_target_out);
    end
    set_bubble();
    tick();
  endtask

  task automatic test_early_ready_branch_suppress();
    set_load(32'h1C0, 5'd11);
    dmem_ready = 1'b1;
    tick();
    dmem_ready = 1'b0;
    tick();
    tests++;
    if (dmem_req !== 1'b1 || mem_stall !== 1'b1) begin
      fails++;
      $display("FAIL early_ready_ignored: req=%b stall=%b expected 1 1", dmem_req, mem_stall);
    end
    branch_in = 1'b1;
    zero_in   = 1'b1;
    #1;
    tests++;
    if (pcsrc_out !== 1'b0) begin
      fails++;
      $display("FAIL branch_suppressed: pcsrc got %b expected 0", pcsrc_out);
    end
    dmem_ready = 1'b1;
    dmem_rdata = 32'hCAFEF00D;
    tick();
    dmem_ready = 1'b0;
    tests++;
    if (wb_data !== 32'hCAFEF00D || wb_rd !== 5'd11 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL early_ready_wb: wb_data=%h wb_rd=%0d wb_regwrite=%b expected cafef00d 11 1",
               wb_data, wb_rd, wb_regwrite);
    end
    tick();
    set_bubble();
    tick();
  endtask

  task automatic test_back_to_back();
    // Second load follows the DONE cycle with a single idle gap.
    set_load(32'h10, 5'd12);
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h11112222;
    tick();
    dmem_ready = 1'b0;
    tick();
    set_load(32'h14, 5'd13);
    // A load with memreg clear writes back the address.
    memreg_in = 1'b0;
    #1;
    tests++;
    if (mem_stall !== 1'b1 || wb_data !== 32'h11112222) begin
      fails++;
      $display("FAIL b2b_second_seen: stall=%b wb_data=%h expected 1 11112222", mem_stall, wb_data);
    end
    tick();
    dmem_ready = 1'b1;
    dmem_rdata = 32'h33334444;
    tests++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h14) begin
      fails++;
      $display("FAIL b2b_second_req: req=%b addr=%h expected 1 00000014", dmem_req, dmem_addr);
    end
    tick();
    dmem_ready = 1'b0;
    tests++;
    if (wb_data !== 32'h14 || wb_rd !== 5'd13 || wb_regwrite !== 1'b1) begin
      fails++;
      $display("FAIL b2b_memreg0_wb: wb_data=%h wb_rd=%0d wb_regwrite=%b expected 00000014 13 1",
               wb_data, wb_rd, wb_regwrite);
    end
    tick();
    set_bubble();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_timeout();
    test_branch();
    test_early_ready_branch_suppress();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
